// File: rtl/mic_pkg.sv
// Shared definitions for the microphone capture path: the sample type and
// helpers that derive pointer/address widths from a buffer depth.
package mic_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra wrap bit lets full and empty be told apart with equal addresses.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mic_fifo_core.sv
// Synchronous FIFO storage: wrap-bit pointers, unreset memory, first-word
// fall-through read. Callers decide when a write or read is allowed.
module mic_fifo_core
  import mic_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [N-1:0]           i_wr_data,
  input  logic                   i_rd_en,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [N-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [N-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  // Modulo-2*DEPTH difference is exact because occupancy never exceeds DEPTH.
  assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/mic_sample_fifo.sv
// Buffers the live microphone sample stream and re-presents it as a stallable
// stream; on overflow the newest sample is dropped and counted.
module mic_sample_fifo
  import mic_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   bclk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [CNT_W-1:0]       drop_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_write;
  logic w_drop;

  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_count;

  // Output stream: a sample transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid depends only on registered pointers.
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_write   = in_valid && (!w_full || w_pop);
  assign w_drop    = in_valid && w_full && !w_pop;

  mic_fifo_core #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_core (
    .i_clk     (bclk),
    .i_rst     (reset),
    .i_wr_en   (w_write),
    .i_wr_data (in_data),
    .i_rd_en   (w_pop),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_rd_data (out_data),
    .o_level   (level)
  );

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (overflow_clr)
        r_drop_count <= CNT_ONE;
      else if (r_drop_count != CNT_MAX)
        r_drop_count <= r_drop_count + CNT_ONE;
    end else if (overflow_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_mic_sample_fifo.sv
// Directed bench for mic_sample_fifo: queue-based reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_mic_sample_fifo;

  localparam int N       = 16;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 4;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             bclk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [N-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             overflow_clr = 1'b0;
  logic [CNT_W-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];
  bit           m_overflow = 1'b0;
  int           m_drops = 0;

  // clock / reset
  always #5 bclk = ~bclk;

  mic_sample_fifo #(
    .N     (N),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .bclk         (bclk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a bounded queue of samples plus the drop bookkeeping
  always @(posedge bclk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_overflow = 1'b0;
      m_drops    = 0;
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (overflow_clr) begin
        m_overflow = 1'b0;
        m_drops    = 0;
      end
      if (in_valid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(in_data);
        else begin
          m_overflow = 1'b1;
          m_drops    = (m_drops < CNT_MAX) ? m_drops + 1 : CNT_MAX;
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge bclk) begin
    if (!reset) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
      check("level", 32'(level), 32'(exp_q.size()));
      check("overflow", 32'(overflow), 32'(m_overflow));
      check("drop_count", 32'(drop_count), 32'(m_drops));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input logic [N-1:0] d);
    check("pop_data", 32'(out_data), 32'(d));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    report();
    $finish;
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    #12 reset = 1'b0;
    tick();

    // single sample, one-cycle latency, then one pop
    push(16'h8001);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h8001);
    check("t1_level", 32'(level), 32'd1);
    pop_expect(16'h8001);
    check("t1_valid_after_pop", 32'(out_valid), 32'd0);
    check("t1_level_after_pop", 32'(level), 32'd0);

    // fill to capacity with back-to-back writes
    for (int i = 1; i <= 16; i++) push(N'(i));
    check("t2_level_full", 32'(level), 32'd16);
    check("t2_no_overflow", 32'(overflow), 32'd0);

    // two writes into a full FIFO are dropped
    push(16'hAAAA);
    push(16'hBBBB);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_drop_count", 32'(drop_count), 32'd2);
    check("t3_level", 32'(level), 32'd16);

    // push and pop together while full: no drop
    in_valid = 1'b1;
    in_data  = 16'h1234;
    check("t4_head", 32'(out_data), 32'h0001);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t4_level", 32'(level), 32'd16);
    check("t4_drop_count", 32'(drop_count), 32'd2);
    for (int i = 2; i <= 16; i++) pop_expect(N'(i));
    pop_expect(16'h1234);
    check("t4_drained", 32'(out_valid), 32'd0);

    // clear coinciding with a drop, then clear alone, then saturation
    for (int i = 0; i < 16; i++) push(N'(16'h0100 + i));
    in_valid     = 1'b1;
    in_data      = 16'hDEAD;
    overflow_clr = 1'b1;
    tick();
    in_valid     = 1'b0;
    overflow_clr = 1'b0;
    check("t5_ovf_drop_wins", 32'(overflow), 32'd1);
    check("t5_cnt_drop_wins", 32'(drop_count), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t5_ovf_cleared", 32'(overflow), 32'd0);
    check("t5_cnt_cleared", 32'(drop_count), 32'd0);
    for (int i = 0; i < 20; i++) push(N'(16'h0F00 + i));
    check("t5_cnt_saturated", 32'(drop_count), 32'(CNT_MAX));
    check("t5_ovf_set", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    for (int i = 0; i < 11; i++) pop_expect(N'(16'h0100 + i));
    check("t6_level_before_reset", 32'(level), 32'd5);

    // asynchronous reset mid-stream
    @(posedge bclk);
    #3 reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_level", 32'(level), 32'd0);
    #3 reset = 1'b0;
    tick();
    push(16'h7FFF);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_data", 32'(out_data), 32'h7FFF);
    check("t6_level", 32'(level), 32'd1);
    pop_expect(16'h7FFF);
    tick();

    report();
    $finish;
  end

endmodule

// File: doc/mic_sample_fifo.md
Name: mic_sample_fifo

Overview:
- Downstream consumer of the microphone deserialiser's live sample stream (valid + N-bit sample, no backpressure), in the same bclk domain.
- Buffers samples in a synchronous FIFO and re-presents them on a valid/ready stream so DSP and storage stages may stall without corrupting capture.
- Live audio cannot be stalled upstream, so overflow drops the newest sample, raises a sticky flag and counts drops.

Parameters:
- N, 16, sample width in bits; must match the deserialiser.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of drop counter.

Ports:
- bclk  in  1  clock; same clock as the deserialiser.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle strobe: in_data holds a new sample.
- in_data  in  N  sample, two's complement, MSB-first origin.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  N  head-of-FIFO sample (first-word fall-through).
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one sample dropped since reset/clear.
- overflow_clr  in  1  synchronous clear of overflow and drop_count.
- drop_count  out  CNT_W  saturating count of dropped samples.

Behaviour:
- Reset (async assert, all regs): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, overflow=0, drop_count=0. out_data is don't-care while out_valid=0. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits wide (extra wrap bit):
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and wrap bits differ.
  - Both wrap naturally modulo 2*DEPTH.
- Write = in_valid && (!full || pop). Stores in_data at wr_ptr[addr] and increments wr_ptr on the same edge.
- Pop = out_valid && out_ready. Increments rd_ptr. out_ready while empty is ignored.
- out_valid = !empty, from registered pointers only; no combinational path from in_valid.
- out_data = mem[rd_ptr[addr]], combinational read of registered memory.
- Latency: a sample written at edge k gives out_valid=1 and out_data equal to that sample after edge k when the FIFO was empty (one cycle).
- Simultaneous push and pop:
  - When not empty: both occur and level is unchanged.
  - When full: the write is accepted because the pop frees a slot. No drop.
  - When empty: the write only. No bypass, so out_valid rises next cycle.
- level: +1 on write-only, -1 on pop-only, unchanged otherwise. It always equals wr_ptr - rd_ptr.
- Overflow (in_valid && full && !pop):
  - Sample discarded and pointers unchanged.
  - overflow <= 1.
  - drop_count increments and saturates at 2^CNT_W-1.
- overflow_clr: overflow <= 0 and drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Reset mid-stream: FIFO contents are lost and out_valid drops immediately, asynchronously.
  - The first in_valid after reset release is stored at entry 0.
- in_valid pulses are at most one per cycle. Back-to-back pulses on consecutive edges must be accepted.

Decomposition:
- Shared package mic_pkg:
  - localparam SAMPLE_W=16.
  - typedef logic [SAMPLE_W-1:0] sample_t.
  - function clog2-based widths, used by the deserialiser and this block.
- One sub-module, mic_fifo_core: pointer/memory/full/empty logic, parameterised on N and DEPTH.
- mic_sample_fifo wraps it with drop policy, sticky overflow and counter.

Test Plan:
- Single write of 16'h8001 into empty FIFO, out_ready=0 -> next cycle out_valid=1, out_data=16'h8001, level=1. Then out_ready=1 for one cycle -> out_valid=0, level=0.
- Write 0x0001..0x0010 (DEPTH=16) on consecutive cycles, out_ready=0 -> level=16, overflow=0. Drain -> outputs 0x0001..0x0010 in order across pointer wrap.
- FIFO full, two more in_valid (0xAAAA, 0xBBBB) with out_ready=0 -> both dropped, overflow=1, drop_count=2. Subsequent drain returns the original 16 samples only.
- FIFO full, in_valid=1 with 0x1234 and out_ready=1 in the same cycle -> no drop, level stays 16, 0x1234 emerges last.
- overflow_clr=1 in the same cycle as a drop -> overflow=1, drop_count=1. overflow_clr alone next cycle -> overflow=0, drop_count=0.
- Assert reset with level=5 mid-stream -> out_valid=0, level=0 immediately. After release, write 0x7FFF -> out_data=0x7FFF from entry 0.
